// File: rtl/mips_init_loader.sv
// rtl/mips_init_loader.sv - framed byte-stream loader driving the MIPS core init port
// Assembles big-endian words from START/N/data frames and holds the core in reset until a frame completes.
module mips_init_loader #(
    parameter logic [7:0] START_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TO_W           = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  base_addr,
    output logic        init,
    output logic [7:0]  init_addr,
    output logic [31:0] init_data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      idx_q, idx_d;
    logic [8:0]      count_q, count_d;
    logic [8:0]      words_q, words_d;
    logic [7:0]      base_q, base_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      init_addr_q, init_addr_d;
    logic [31:0]     init_data_q, init_data_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            xfer;

    assign in_ready     = (state_q != S_WRITE);
    assign xfer         = in_valid && in_ready;
    // A reset arriving during WRITE suppresses the strobe in that same cycle.
    assign init         = (state_q == S_WRITE) && !reset;
    assign init_addr    = init_addr_q;
    assign init_data    = init_data_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        count_d     = count_q;
        words_d     = words_q;
        base_d      = base_q;
        to_d        = to_q;
        init_addr_d = init_addr_q;
        init_data_d = init_data_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (xfer && in_data == START_BYTE) begin
                    state_d     = S_COUNT;
                    base_d      = base_addr;
                    words_d     = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    to_d        = '0;
                end
            end
            S_COUNT, S_DATA: begin
                if (xfer) begin
                    to_d = '0;
                    if (state_q == S_COUNT) begin
                        count_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        idx_d   = 2'd0;
                        state_d = S_DATA;
                    end else begin
                        word_d = {word_q[23:0], in_data};
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d     = S_WRITE;
                            init_addr_d = base_q + words_q[7:0];
                            init_data_d = {word_q[23:0], in_data};
                        end
                    end
                end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WRITE: begin
                words_d = words_q + 9'd1;
                if (words_q + 9'd1 == count_q) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cpu_reset_d = 1'b0;
                end else begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                    to_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            words_q     <= '0;
            base_q      <= '0;
            to_q        <= '0;
            init_addr_q <= '0;
            init_data_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            words_q     <= words_d;
            base_q      <= base_d;
            to_q        <= to_d;
            init_addr_q <= init_addr_d;
            init_data_q <= init_data_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_mips_init_loader.sv
// tb/tb_mips_init_loader.sv - self-checking bench for mips_init_loader
// Expected init writes come from a frame-level model: address (base+i) mod 256, data = i-th word.
module tb_mips_init_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  base_addr;
    logic        init;
    logic [7:0]  init_addr;
    logic [31:0] init_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_words[$];
    int cyc = 0, last_xfer = -10, lat_bad = 0, ready_low = 0, n_xfer = 0;

    always #5 clk = ~clk;

    mips_init_loader #(
        .START_BYTE(8'hA5), .TIMEOUT_CYCLES(1000), .TO_W(10)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .base_addr(base_addr), .init(init),
        .init_addr(init_addr), .init_data(init_data), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always @(negedge clk) begin
        cyc++;
        if (init) begin
            obs_addr.push_back(init_addr);
            obs_data.push_back(init_data);
            if (cyc != last_xfer + 1) lat_bad++;
        end
        if (!in_ready) ready_low++;
        if (in_valid && in_ready) begin
            last_xfer = cyc;
            n_xfer++;
        end
    end

    task automatic clear_mon();
        obs_addr.delete();
        obs_data.delete();
        lat_bad   = 0;
        ready_low = 0;
        n_xfer    = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 20) begin
                n_checks++;
                $display("FAIL send_timeout: in_ready stuck at %b for byte %h", in_ready, b);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [7:0] base, input int n, input int gapmax);
        logic [31:0] w;
        base_addr = base;
        send_byte(8'hA5, $urandom_range(0, gapmax));
        send_byte(n[7:0], $urandom_range(0, gapmax));
        for (int i = 0; i < exp_words.size(); i++) begin
            w = exp_words[i];
            for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], $urandom_range(0, gapmax));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (init !== 1'b0) $display("FAIL reset_init: got %b expected 0", init); else n_pass++;
        n_checks++; if ({init_addr, init_data} !== 40'd0) $display("FAIL reset_init_port: got %h/%h expected 0/0", init_addr, init_data); else n_pass++;
        n_checks++; if ({cpu_reset, busy, done, error} !== 4'b1000) $display("FAIL reset_flags: got %b expected 1000", {cpu_reset, busy, done, error}); else n_pass++;
        n_checks++; if (words_loaded !== 9'd0) $display("FAIL reset_words: got %0d expected 0", words_loaded); else n_pass++;
    endtask

    task automatic test_basic();
        int mism = 0;
        clear_mon();
        exp_words = '{32'h11223344, 32'hDEADBEEF};
        run_frame(8'h10, 2, 3);
        for (int i = 0; i < obs_addr.size() && i < 2; i++)
            if (obs_addr[i] !== 8'(8'h10 + i) || obs_data[i] !== exp_words[i]) mism++;
        n_checks++; if (obs_addr.size() != 2) $display("FAIL basic_init_count: got %0d expected 2", obs_addr.size()); else n_pass++;
        n_checks++; if (mism != 0) $display("FAIL basic_writes: got %0d bad writes expected 0", mism); else n_pass++;
        n_checks++; if ({done, cpu_reset, busy} !== 3'b100) $display("FAIL basic_flags: got %b expected 100", {done, cpu_reset, busy}); else n_pass++;
        n_checks++; if (words_loaded !== 9'd2) $display("FAIL basic_words: got %0d expected 2", words_loaded); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int mism = 0;
        clear_mon();
        exp_words = '{$urandom, $urandom};
        run_frame(8'h10, 2, 0);
        for (int i = 0; i < obs_addr.size() && i < 2; i++)
            if (obs_addr[i] !== 8'(8'h10 + i) || obs_data[i] !== exp_words[i]) mism++;
        n_checks++; if (ready_low != 2) $display("FAIL b2b_ready_low: got %0d cycles expected 2", ready_low); else n_pass++;
        n_checks++; if (lat_bad != 0 || obs_addr.size() != 2) $display("FAIL b2b_latency: got %0d late of %0d inits expected 0 of 2", lat_bad, obs_addr.size()); else n_pass++;
        n_checks++; if (n_xfer != 10 || mism != 0) $display("FAIL b2b_data: got %0d bytes %0d bad writes expected 10 bytes 0 bad", n_xfer, mism); else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(1, 6);
            logic [7:0] base = 8'($urandom);
            int mism = 0;
            clear_mon();
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            run_frame(base, n, 3);
            for (int i = 0; i < obs_addr.size() && i < n; i++)
                if (obs_addr[i] !== 8'(base + i) || obs_data[i] !== exp_words[i]) mism++;
            n_checks++;
            if (obs_addr.size() != n || mism != 0 || words_loaded !== 9'(n) || done !== 1'b1)
                $display("FAIL rand_frame%0d: got %0d inits %0d bad words_loaded %0d done %b expected %0d inits 0 bad done 1",
                         f, obs_addr.size(), mism, words_loaded, done, n);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_count0();
        int mism = 0;
        clear_mon();
        exp_words.delete();
        for (int i = 0; i < 256; i++) exp_words.push_back(32'(i));
        run_frame(8'hFF, 0, 0);
        for (int i = 0; i < obs_addr.size() && i < 256; i++)
            if (obs_addr[i] !== 8'(8'hFF + i) || obs_data[i] !== exp_words[i]) mism++;
        n_checks++; if (obs_addr.size() != 256) $display("FAIL wrap_init_count: got %0d expected 256", obs_addr.size()); else n_pass++;
        if (obs_addr.size() == 256) begin
            n_checks++;
            if ({obs_addr[0], obs_addr[1], obs_addr[255]} !== 24'hFF00FE)
                $display("FAIL wrap_addrs: got %h %h %h expected ff 00 fe", obs_addr[0], obs_addr[1], obs_addr[255]);
            else n_pass++;
        end
        n_checks++; if (mism != 0) $display("FAIL wrap_writes: got %0d bad writes expected 0", mism); else n_pass++;
        n_checks++; if (words_loaded !== 9'd256 || done !== 1'b1 || error !== 1'b0) $display("FAIL wrap_final: got words %0d done %b error %b expected 256 1 0", words_loaded, done, error); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_mon();
        base_addr = 8'h40;
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        for (int b = 0; b < 6; b++) send_byte(8'(8'h20 + b), 0);
        in_valid = 1'b0;
        repeat (999) @(posedge clk);
        #1;
        n_checks++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early: got error %b busy %b expected 0 1", error, busy); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if ({error, cpu_reset, busy, done} !== 4'b1100) $display("FAIL timeout_flags: got %b expected 1100", {error, cpu_reset, busy, done}); else n_pass++;
        n_checks++; if (words_loaded !== 9'd1 || obs_addr.size() != 1) $display("FAIL timeout_partial: got words %0d inits %0d expected 1 1", words_loaded, obs_addr.size()); else n_pass++;
    endtask

    task automatic test_noise_restart();
        logic [7:0] base = 8'($urandom);
        clear_mon();
        send_byte(8'h00, 1);
        send_byte(8'h7F, 1);
        n_checks++; if (error !== 1'b1 || busy !== 1'b0) $display("FAIL noise_ignored: got error %b busy %b expected 1 0", error, busy); else n_pass++;
        exp_words = '{32'hA5A5A5A5};
        run_frame(base, 1, 2);
        n_checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== base || obs_data[0] !== 32'hA5A5A5A5 || done !== 1'b1)
            $display("FAIL noise_data_a5: got %0d inits done %b expected 1 init of a5a5a5a5 done 1", obs_addr.size(), done);
        else n_pass++;
        send_byte(8'hA5, 0);
        in_valid = 1'b0;
        n_checks++; if ({cpu_reset, done, busy} !== 3'b101) $display("FAIL restart_flags: got %b expected 101", {cpu_reset, done, busy}); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int mism = 0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        base_addr = 8'h33;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        for (int b = 0; b < 4; b++) send_byte(8'(8'h90 + b), 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (init !== 1'b0) $display("FAIL midreset_init: got %b expected 0", init); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if ({in_ready, cpu_reset, busy, done, error} !== 5'b11000 || words_loaded !== 9'd0 || {init_addr, init_data} !== 40'd0 || obs_addr.size() != 0)
            $display("FAIL midreset_state: got flags %b words %0d port %h/%h inits %0d expected 11000 0 0/0 0",
                     {in_ready, cpu_reset, busy, done, error}, words_loaded, init_addr, init_data, obs_addr.size());
        else n_pass++;
        clear_mon();
        exp_words = '{$urandom, $urandom};
        run_frame(8'h80, 2, 1);
        for (int i = 0; i < obs_addr.size() && i < 2; i++)
            if (obs_addr[i] !== 8'(8'h80 + i) || obs_data[i] !== exp_words[i]) mism++;
        n_checks++; if (obs_addr.size() != 2 || mism != 0 || done !== 1'b1) $display("FAIL midreset_reload: got %0d inits %0d bad done %b expected 2 0 1", obs_addr.size(), mism, done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_frames();
        test_wrap_count0();
        test_timeout();
        test_noise_restart();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
